r_peak_detect: RTL

Adaptive-threshold R-peak detector sitting directly upstream of the qrs R-R interval stage. It consumes the preprocessed ECG feature stream (moving-window-integrated energy) one sample per sample_valid strobe. It drives the slope_ and r_peak inputs of qrs, qualifying local maxima against a running signal/noise threshold and suppressing re-triggers during a refractory window.

---
 rtl/r_peak_pkg.sv | 15 +
 rtl/r_peak_detect_level_avg.sv | 14 +
 rtl/r_peak_detect.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/r_peak_pkg.sv
// Shared types and constants for the adaptive-threshold R-peak detector.
package r_peak_pkg;

  typedef enum logic [1:0] {
    ST_LEARN   = 2'd0,
    ST_SEARCH  = 2'd1,
    ST_REFRACT = 2'd2
  } state_e;

  // Threshold sits a quarter of the way from the noise level up to the signal level.
  localparam int THR_SHIFT = 2;
  // Running levels move 1/8 of the way toward each new candidate.
  localparam int AVG_SHIFT = 3;

endpackage

// File: rtl/r_peak_detect_level_avg.sv
// Exponential level updater: level - level/8 + cand/8, shared by the SPK and NPK paths.
module level_avg
  import r_peak_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] level_i,
  input  logic [DATA_W-1:0] cand_i,
  output logic [DATA_W-1:0] level_o
);

  assign level_o = level_i - (level_i >> AVG_SHIFT) + (cand_i >> AVG_SHIFT);

endmodule

// File: rtl/r_peak_detect.sv
// Adaptive-threshold R-peak detector feeding the qrs R-R interval stage.
// Optional macro THR_DECAY_EN halves SPK after DECAY_N peak-free valid samples in SEARCH.
module r_peak_detect
  import r_peak_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int LEARN_N = 8,
  parameter int REFRACT = 72,
  parameter int DECAY_N = 720
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  output logic              slope_,
  output logic              r_peak,
  output logic [DATA_W-1:0] peak_val,
  output logic [DATA_W-1:0] thr_out
);

  localparam int LEARN_W = $clog2(LEARN_N + 1);
  localparam int REFR_W  = $clog2(REFRACT + 1);

  state_e              state_q;
  logic [DATA_W-1:0]   prev_q, spk_q, npk_q, learn_max_q, peak_val_q, thr_q;
  logic [DATA_W-1:0]   spk_d, npk_d, thr_d, thr_cur, learn_max_nx;
  logic [DATA_W-1:0]   spk_avg, npk_avg;
  logic [LEARN_W-1:0]  learn_cnt_q;
  logic [REFR_W-1:0]   refr_cnt_q;
  logic                slope_q, rising_q, r_peak_q;
  logic                cand_v, accept, noise, learn_done;

  function automatic logic [DATA_W-1:0] thr_of(input logic [DATA_W-1:0] s,
                                                input logic [DATA_W-1:0] n);
    return (s > n) ? n + ((s - n) >> THR_SHIFT) : n;
  endfunction

  level_avg #(.DATA_W(DATA_W)) u_spk_avg (.level_i(spk_q), .cand_i(prev_q), .level_o(spk_avg));
  level_avg #(.DATA_W(DATA_W)) u_npk_avg (.level_i(npk_q), .cand_i(prev_q), .level_o(npk_avg));

  // A local maximum is declared on the first non-rising sample; the candidate is the previous one.
  assign thr_cur      = thr_of(spk_q, npk_q);
  assign cand_v       = sample_valid && rising_q && (sample <= prev_q);
  assign accept       = cand_v && (state_q == ST_SEARCH) && (prev_q > thr_cur);
  assign noise        = cand_v && (state_q == ST_SEARCH) && !(prev_q > thr_cur);
  assign learn_done   = sample_valid && (state_q == ST_LEARN) &&
                        (learn_cnt_q == LEARN_W'(LEARN_N - 1));
  assign learn_max_nx = (sample > learn_max_q) ? sample : learn_max_q;

`ifdef THR_DECAY_EN
  localparam int DECAY_W = $clog2(DECAY_N + 1);
  logic [DECAY_W-1:0] decay_cnt_q;
  logic               decay_hit;

  assign decay_hit = sample_valid && (state_q == ST_SEARCH) && !accept &&
                     (decay_cnt_q == DECAY_W'(DECAY_N - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      decay_cnt_q <= '0;
    end else if (sample_valid && (state_q == ST_SEARCH)) begin
      decay_cnt_q <= (accept || decay_hit) ? '0 : decay_cnt_q + DECAY_W'(1);
    end
  end
`endif

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    spk_d = spk_q;
    npk_d = npk_q;
    if (learn_done) begin
      spk_d = learn_max_nx;
      npk_d = '0;
    end else if (accept) begin
      spk_d = spk_avg;
    end else if (noise) begin
      npk_d = npk_avg;
    end
`ifdef THR_DECAY_EN
    if (decay_hit) spk_d = spk_q >> 1;
`endif
    thr_d = thr_of(spk_d, npk_d);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_LEARN;
      prev_q      <= '0;
      spk_q       <= '0;
      npk_q       <= '0;
      learn_max_q <= '0;
      peak_val_q  <= '0;
      thr_q       <= '0;
      learn_cnt_q <= '0;
      refr_cnt_q  <= '0;
      slope_q     <= 1'b0;
      rising_q    <= 1'b0;
      r_peak_q    <= 1'b0;
    end else begin
      r_peak_q <= 1'b0;
      if (sample_valid) begin
        prev_q   <= sample;
        slope_q  <= (sample > prev_q);
        rising_q <= (sample > prev_q);
        spk_q    <= spk_d;
        npk_q    <= npk_d;
        thr_q    <= thr_d;
        case (state_q)
          ST_LEARN: begin
            learn_max_q <= learn_max_nx;
            if (learn_done) begin
              learn_cnt_q <= '0;
              state_q     <= ST_SEARCH;
            end else begin
              learn_cnt_q <= learn_cnt_q + LEARN_W'(1);
            end
          end
          ST_SEARCH: begin
            if (accept) begin
              r_peak_q   <= 1'b1;
              peak_val_q <= prev_q;
              refr_cnt_q <= REFR_W'(REFRACT);
              state_q    <= ST_REFRACT;
            end
          end
          ST_REFRACT: begin
            // Candidates here are ignored, including on the sample that empties the counter.
            refr_cnt_q <= refr_cnt_q - REFR_W'(1);
            if (refr_cnt_q == REFR_W'(1)) state_q <= ST_SEARCH;
          end
          default: state_q <= ST_LEARN;
        endcase
      end
    end
  end

  assign slope_   = slope_q;
  assign r_peak   = r_peak_q;
  assign peak_val = peak_val_q;
  assign thr_out  = thr_q;

endmodule
